// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared types, default sizes and the product sign-extension
//                helper for the mul_mac_seq initiator.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

  // Default sizes; the top exposes these as overridable parameters.
  localparam int DEF_WIDTH     = 16;
  localparam int DEF_ACC_WIDTH = 40;
  localparam int DEF_CNT_WIDTH = 8;
  localparam int DEF_TIMEOUT   = 64;

  // Widest value the sign-extension helper handles; ACC_WIDTH must not exceed it.
  localparam int SEXT_MAX_W    = 128;
  localparam int SEXT_IDX_W    = $clog2(SEXT_MAX_W);

  // Initiator FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } mac_state_t;

  // Replicate bit (from_w-1) of value into every higher bit position.
  // Callers zero-extend into SEXT_MAX_W bits and truncate the result to the
  // accumulator width, so a single helper serves any WIDTH/ACC_WIDTH pairing.
  function automatic logic [SEXT_MAX_W-1:0] sign_extend(
    input logic [SEXT_MAX_W-1:0] value,
    input int                    from_w
  );
    logic [SEXT_MAX_W-1:0] res;
    logic [SEXT_IDX_W-1:0] msb_idx;
    logic                  sign;
    res     = value;
    msb_idx = SEXT_IDX_W'(from_w - 1);
    sign    = value[msb_idx];
    for (int i = 0; i < SEXT_MAX_W; i++) begin
      if (i >= from_w) begin
        res[i] = sign;
      end
    end
    return res;
  endfunction

endpackage : mul_pkg
`default_nettype wire

// File: rtl/mul_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mul_mac_seq
//  Description : Initiator for the start_mul/done_mul multiplier handshake.
//                Takes signed operand pairs over valid/ready, issues each to
//                the shared multiplier, accumulates the signed products and
//                presents the sum when the pair tagged in_last completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_mac_seq
  import mul_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,   // must be >= 2*WIDTH
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int TIMEOUT   = DEF_TIMEOUT      // must be >= 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  // operand stream
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic                   in_last,
  // multiplier handshake
  output logic                   start_mul,
  output logic [WIDTH-1:0]       mul_a,
  output logic [WIDTH-1:0]       mul_b,
  input  logic [2*WIDTH-1:0]     product,
  input  logic                   done_mul,
  // result
  output logic                   acc_valid,
  output logic [ACC_WIDTH-1:0]   acc_out,
  output logic [CNT_WIDTH-1:0]   acc_count,
  output logic                   timeout_err,
  output logic                   busy
);

  // The timer only ever needs to hold 0 .. TIMEOUT-1.
  localparam int                    TMO_WIDTH = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_WIDTH-1:0]  TMO_LAST  = TMO_WIDTH'(TIMEOUT - 1);

  mac_state_t            state_q,       state_d;
  logic [WIDTH-1:0]      mul_a_q,       mul_a_d;
  logic [WIDTH-1:0]      mul_b_q,       mul_b_d;
  logic                  last_q,        last_d;
  logic [ACC_WIDTH-1:0]  acc_q,         acc_d;
  logic [CNT_WIDTH-1:0]  cnt_q,         cnt_d;
  logic [TMO_WIDTH-1:0]  tmo_q,         tmo_d;
  logic                  terr_q,        terr_d;
  // Visible copies of the running sum; unlike acc_q they are not cleared
  // after DONE, so acc_out/acc_count keep their last value between sums.
  logic [ACC_WIDTH-1:0]  acc_out_q,     acc_out_d;
  logic [CNT_WIDTH-1:0]  acc_count_q,   acc_count_d;

  logic [ACC_WIDTH-1:0]  product_ext;

  // Product widened to the accumulator with its sign preserved.
  assign product_ext = ACC_WIDTH'(sign_extend(SEXT_MAX_W'(product), 2 * WIDTH));

  // Next-state and datapath updates for the issue/wait/accumulate sequence.
  always_comb begin
    state_d     = state_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    last_d      = last_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    terr_d      = terr_q;
    acc_out_d   = acc_out_q;
    acc_count_d = acc_count_q;

    unique case (state_q)
      IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone is the handshake.
        if (in_valid) begin
          mul_a_d = in_a;
          mul_b_d = in_b;
          last_d  = in_last;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        tmo_d = tmo_q + 1'b1;
        // A response on the final timer cycle still counts: done_mul wins.
        if (done_mul) begin
          acc_d       = acc_q + product_ext;
          cnt_d       = cnt_q + 1'b1;
          acc_out_d   = acc_q + product_ext;
          acc_count_d = cnt_q + 1'b1;
          state_d     = last_q ? DONE : IDLE;
        end else if (tmo_q == TMO_LAST) begin
          // Abandon the pair and close the sum with what was gathered so far.
          terr_d      = 1'b1;
          acc_out_d   = acc_q;
          acc_count_d = cnt_q;
          state_d     = DONE;
        end
      end

      DONE: begin
        acc_d   = '0;
        cnt_d   = '0;
        terr_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any pending pair and partial sum.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      last_q      <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      terr_q      <= 1'b0;
      acc_out_q   <= '0;
      acc_count_q <= '0;
    end else begin
      state_q     <= state_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      terr_q      <= terr_d;
      acc_out_q   <= acc_out_d;
      acc_count_q <= acc_count_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign start_mul   = (state_q == ISSUE);
  assign acc_valid   = (state_q == DONE);
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign acc_out     = acc_out_q;
  assign acc_count   = acc_count_q;
  assign timeout_err = terr_q;

endmodule : mul_mac_seq
`default_nettype wire

// File: tb/tb_mul_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_mac_seq
//  Description : Self-checking bench for mul_mac_seq with a behavioural
//                multiplier stub (programmable latency, never-respond mode,
//                injectable spurious done_mul pulses).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_mac_seq;

  localparam int WIDTH     = 16;
  localparam int ACC_WIDTH = 40;
  localparam int CNT_WIDTH = 8;
  localparam int TIMEOUT   = 64;

  logic                 clk       = 1'b0;
  logic                 reset_n   = 1'b0;
  logic                 in_valid  = 1'b0;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a      = '0;
  logic [WIDTH-1:0]     in_b      = '0;
  logic                 in_last   = 1'b0;
  logic                 start_mul;
  logic [WIDTH-1:0]     mul_a;
  logic [WIDTH-1:0]     mul_b;
  logic [2*WIDTH-1:0]   product   = '0;
  logic                 done_mul  = 1'b0;
  logic                 acc_valid;
  logic [ACC_WIDTH-1:0] acc_out;
  logic [CNT_WIDTH-1:0] acc_count;
  logic                 timeout_err;
  logic                 busy;

  mul_mac_seq #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .CNT_WIDTH (CNT_WIDTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_last     (in_last),
    .start_mul   (start_mul),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .product     (product),
    .done_mul    (done_mul),
    .acc_valid   (acc_valid),
    .acc_out     (acc_out),
    .acc_count   (acc_count),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  // Rising edges counted in cyc; everything else is sampled/driven on negedges.
  int cyc = 0;
  initial begin
    forever begin
      #5 clk = 1'b1;
      cyc++;
      #5 clk = 1'b0;
    end
  end

  typedef struct {
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 terr;
  } sum_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

  sum_t  sb_q[$];      // expected acc_valid results
  pair_t iq[$];        // expected start_mul operands

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int last_valid_cyc = 0;
  int accept_cyc = 0;

  // stub controls
  int               lat     = 0;
  bit               never   = 1'b0;
  int               inj_cnt = 0;
  logic [31:0]      inj_val = '0;

  // reference model state
  logic [ACC_WIDTH-1:0] m_acc = '0;
  logic [CNT_WIDTH-1:0] m_cnt = '0;

  function automatic logic [31:0] smul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  task automatic sb_push(input logic [ACC_WIDTH-1:0] acc, input logic [CNT_WIDTH-1:0] cnt, input logic terr);
    sum_t s;
    s.acc  = acc;
    s.cnt  = cnt;
    s.terr = terr;
    sb_q.push_back(s);
  endtask

  // Present one pair from a negedge; returns at the negedge following its acceptance.
  // in_valid is left high so back-to-back calls form a continuous stream.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic last);
    int    g;
    pair_t p;
    g        = 0;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      bound_fail("accept");
      in_valid = 1'b0;
      return;
    end
    p.a = a;
    p.b = b;
    iq.push_back(p);
    @(negedge clk);
    accept_cyc = cyc;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int g;
    g = 0;
    while ((busy || sb_q.size() != 0) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (busy || sb_q.size() != 0) bound_fail(name);
  endtask

  // Model-driven pair: accumulate the reference and queue the sum on the last pair.
  task automatic model_send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic last);
    logic [31:0] p;
    p     = smul(a, b);
    m_acc = m_acc + {{(ACC_WIDTH-32){p[31]}}, p};
    m_cnt = m_cnt + 1'b1;
    if (last) begin
      sb_push(m_acc, m_cnt, 1'b0);
      m_acc = '0;
      m_cnt = '0;
    end
    send(a, b, last);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"},    64'(in_ready),    64'd1);
    chk({tag, "_start_mul"},   64'(start_mul),   64'd0);
    chk({tag, "_mul_a"},       64'(mul_a),       64'd0);
    chk({tag, "_mul_b"},       64'(mul_b),       64'd0);
    chk({tag, "_acc_valid"},   64'(acc_valid),   64'd0);
    chk({tag, "_acc_out"},     64'(acc_out),     64'd0);
    chk({tag, "_acc_count"},   64'(acc_count),   64'd0);
    chk({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
    chk({tag, "_busy"},        64'(busy),        64'd0);
  endtask

  initial begin
    fork
      // ---------------- stimulus ----------------
      begin : stim
        int v0;
        int np;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rl;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_values("reset");

        // single pair: 201*102
        v0 = n_valid;
        sb_push(40'd20502, 8'd1, 1'b0);
        send(16'd201, 16'd102, 1'b1);
        idle_in();
        wait_idle("single");
        chk("single_valid_pulses", 64'(n_valid - v0), 64'd1);

        // three pairs: 20502 - 21 - 10000 = 10481
        v0 = n_valid;
        send(16'd201, 16'd102, 1'b0);
        idle_in();
        wait_idle("three_p1");
        chk("three_count_after_1", 64'(acc_count), 64'd1);
        chk("three_acc_after_1",   64'(acc_out),   64'd20502);
        send(-16'sd3, 16'sd7, 1'b0);
        idle_in();
        wait_idle("three_p2");
        chk("three_count_after_2", 64'(acc_count), 64'd2);
        chk("three_acc_after_2",   64'(acc_out),   64'd20481);
        sb_push(40'd10481, 8'd3, 1'b0);
        send(16'sd100, -16'sd100, 1'b1);
        idle_in();
        wait_idle("three_p3");
        chk("three_valid_pulses", 64'(n_valid - v0), 64'd1);
        chk("three_hold_acc",     64'(acc_out),      64'd10481);

        // multiplier never answers: empty sum with timeout_err
        never = 1'b1;
        v0 = n_valid;
        sb_push('0, '0, 1'b1);
        send(16'd5, 16'd5, 1'b1);
        idle_in();
        wait_idle("timeout");
        // The DONE cycle is the (TIMEOUT+2)th cycle counting the one that
        // starts at the accept edge as the first: TIMEOUT+1 rising edges later.
        chk("timeout_latency", 64'(last_valid_cyc - accept_cyc), 64'(TIMEOUT + 1));
        chk("timeout_valid_pulses", 64'(n_valid - v0), 64'd1);
        never = 1'b0;
        sb_push(40'd6, 8'd1, 1'b0);
        send(16'd2, 16'd3, 1'b1);
        idle_in();
        wait_idle("after_timeout");

        // spurious done_mul while idle must not be accumulated
        repeat (2) @(negedge clk);
        inj_val = 32'h7FFF_FFFF;
        inj_cnt++;
        repeat (4) @(negedge clk);
        sb_push(40'd1, 8'd1, 1'b0);
        send(16'd1, 16'd1, 1'b1);
        idle_in();
        wait_idle("spurious");

        // reset while waiting; a late done_mul lands in IDLE
        never = 1'b1;
        send(16'd9, 16'd9, 1'b1);
        idle_in();
        @(negedge clk);
        chk("pre_reset_in_wait_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_reset_values("midreset");
        inj_val = 32'd500;
        inj_cnt++;
        repeat (5) @(negedge clk);
        chk("late_done_ignored_acc", 64'(acc_out), 64'd0);
        chk("late_done_ignored_busy", 64'(busy), 64'd0);
        never = 1'b0;
        sb_push(40'd20, 8'd1, 1'b0);
        send(16'd4, 16'd5, 1'b1);
        idle_in();
        wait_idle("after_reset");

        // continuous streams at three stub latencies, 200 pairs in total
        m_acc = '0;
        m_cnt = '0;
        model_send(16'h8000, 16'h8000, 1'b0);   // most-negative squared
        model_send(16'h7FFF, 16'h8000, 1'b1);
        idle_in();
        wait_idle("corner");
        for (int l = 0; l < 3; l++) begin
          lat = (l == 0) ? 0 : ((l == 1) ? 1 : 7);
          np  = (l == 2) ? 64 : 67;
          for (int i = 0; i < np; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rl = (i == np - 1) || ($urandom_range(0, 4) == 0);
            model_send(ra, rb, rl);
          end
          idle_in();
          wait_idle("stream");
          chk("stream_issue_drained", 64'(iq.size()), 64'd0);
        end
        repeat (3) @(negedge clk);
      end

      // ---------------- monitor / scoreboard ----------------
      begin : mon
        sum_t  s;
        pair_t p;
        forever begin
          @(negedge clk);
          if (reset_n) begin
            if (busy) chk("in_ready_low_when_busy", 64'(in_ready), 64'd0);
            else      chk("in_ready_high_when_idle", 64'(in_ready), 64'd1);
            if (start_mul) begin
              if (iq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_start_mul: got start_mul=1 expected no issue (cycle %0d)", cyc);
              end else begin
                p = iq.pop_front();
                chk("mul_a", 64'(mul_a), 64'(p.a));
                chk("mul_b", 64'(mul_b), 64'(p.b));
              end
            end
            if (acc_valid) begin
              n_valid++;
              last_valid_cyc = cyc;
              if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_acc_valid: got acc_out=%0h expected no result (cycle %0d)", acc_out, cyc);
              end else begin
                s = sb_q.pop_front();
                chk("acc_out",     64'(acc_out),     64'(s.acc));
                chk("acc_count",   64'(acc_count),   64'(s.cnt));
                chk("timeout_err", 64'(timeout_err), 64'(s.terr));
              end
            end
          end
        end
      end

      // ---------------- behavioural multiplier stub ----------------
      begin : stub
        int          cd;
        int          inj_seen;
        logic [31:0] pend;
        cd       = -1;
        inj_seen = 0;
        pend     = '0;
        forever begin
          @(negedge clk);
          done_mul = 1'b0;
          if (inj_cnt != inj_seen) begin
            inj_seen = inj_cnt;
            done_mul = 1'b1;
            product  = inj_val;
          end else if (cd == 0) begin
            done_mul = 1'b1;
            product  = pend;
            cd       = -1;
          end else if (cd > 0) begin
            cd--;
          end
          if (start_mul && !never) begin
            pend = smul(mul_a, mul_b);
            cd   = lat;
          end
        end
      end

      // ---------------- watchdog ----------------
      begin : wdog
        repeat (80000) @(posedge clk);
        bound_fail("watchdog");
      end
    join_any
    disable fork;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mul_mac_seq
`default_nettype wire

// File: doc/mul_mac_seq.md
Name: mul_mac_seq

Overview:
- Initiator side of the `start_mul` / `done_mul` multiplier handshake.
- Accepts a stream of signed operand pairs over a valid/ready interface and issues each pair to the shared `mul` unit.
- Waits for `done_mul`, then accumulates each signed product into a wide accumulator.
- Presents the sum when the pair flagged `in_last` completes.
- Sits between the software-facing operand FIFO and `mul`, replacing ad-hoc bench sequencing.

Parameters:
- WIDTH, 16, operand width; `mul` returns a 2*WIDTH product.
- ACC_WIDTH, 40, accumulator width; must be >= 2*WIDTH.
- CNT_WIDTH, 8, width of the accumulated-pair counter.
- TIMEOUT, 64, max cycles in WAIT before abandoning the pair; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair.
- in_a  in  WIDTH  signed operand A.
- in_b  in  WIDTH  signed operand B.
- in_last  in  1  final pair of the current sum.
- start_mul  out  1  one-cycle request pulse to `mul`.
- mul_a  out  WIDTH  operand A to `mul`.
- mul_b  out  WIDTH  operand B to `mul`.
- product  in  2*WIDTH  signed product from `mul`; valid only while done_mul=1.
- done_mul  in  1  one-cycle completion pulse from `mul`.
- acc_valid  out  1  one-cycle pulse; acc_out/acc_count valid.
- acc_out  out  ACC_WIDTH  signed accumulated sum.
- acc_count  out  CNT_WIDTH  number of products in acc_out.
- timeout_err  out  1  qualifies acc_valid: sum was truncated by a timeout.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset:
  - Clock is `clk`; reset is `reset_n`, synchronous, active-low, sampled on the rising edge of clk.
  - Reset values: in_ready=1 (from the first cycle after reset), start_mul=0, mul_a=0, mul_b=0, acc_valid=0, acc_out=0, acc_count=0, timeout_err=0, busy=0, state=IDLE.
  - Reset mid-operation discards any pending pair and the partial sum.
  - A later done_mul from `mul` lands in IDLE and is ignored.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register in_a→mul_a, in_b→mul_b and in_last→last_q, then go to ISSUE.
- ISSUE:
  - start_mul=1 for exactly this cycle.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - mul_a/mul_b are held stable.
  - The timeout counter increments each cycle.
  - If done_mul: acc ← acc + sign_extend(product), wrapping modulo 2^ACC_WIDTH; acc_count ← acc_count+1, wrapping. Then go to DONE if last_q, else to IDLE.
  - Else, if the counter reaches TIMEOUT-1: timeout_err_q ← 1, the pair is dropped, go to DONE.
  - done_mul on the same cycle as the timeout: done_mul wins.
- DONE:
  - acc_valid=1 for one cycle; acc_out, acc_count and timeout_err are driven.
  - Next edge: acc, acc_count and timeout_err_q clear; go to IDLE.
- in_ready is 0 in ISSUE, WAIT and DONE.
- done_mul in IDLE, ISSUE or DONE is ignored and is not accumulated.
- Latency:
  - Accept at edge N; start_mul high in cycle N+1.
  - With `mul` latency L (done_mul sampled at edge N+1+L), the accumulator updates on that edge.
  - acc_valid is high in the following cycle when last_q=1.
  - Minimum throughput: one pair per L+3 cycles.
- acc_out and acc_count hold their last value outside acc_valid. Consumers use them only when qualified.
- Overflow of the accumulator wraps silently. Choosing ACC_WIDTH is the integrator's responsibility.

Decomposition:
- Shared package `mul_pkg`:
  - State enum `mac_state_t` (IDLE, ISSUE, WAIT, DONE).
  - Default WIDTH / ACC_WIDTH constants.
  - A sign-extension function for product→accumulator.
- No sub-module. The timeout counter and accumulator are inline.
- The bench instantiates the existing `mul`, plus a behavioural `mul` stub with programmable latency and a "never respond" mode.

Test Plan:
- Single pair, in_a=201, in_b=102, in_last=1:
  - start_mul pulses once with mul_a=201, mul_b=102.
  - acc_valid pulse with acc_out=20502, acc_count=1, timeout_err=0.
- Three pairs (201,102), (-3,7), (100,-100, last):
  - acc_out=10481, acc_count=1..3 progression, exactly one acc_valid.
  - in_ready low throughout each ISSUE/WAIT/DONE.
- Stub never asserts done_mul, single pair with in_last=1:
  - acc_valid with timeout_err=1, acc_out=0, acc_count=0, exactly TIMEOUT+2 cycles after the accept edge.
  - Next sum, (2,3, last), yields acc_out=6 with timeout_err=0.
- Spurious done_mul with product=0x7FFF_FFFF while in IDLE, then pair (1,1, last):
  - acc_out=1, with no contribution from the spurious pulse.
- Reset mid-WAIT:
  - Assert reset_n=0 for one edge after start_mul; the stub then asserts done_mul with product=500.
  - All outputs return to reset values, and the late done_mul is ignored.
  - Next sum, (4,5, last), gives acc_out=20.
- Stub latency 0/1/7 with in_valid held high continuously:
  - Each pair is accepted exactly once and no pair is lost or duplicated.
  - Sums match a reference model over 200 random signed pairs.
